// File: rtl/uart_pkg.sv
// uart_pkg: shared types, default sizing and helpers for the UART receive path.
//   rx_state_t    receiver FSM states (IDLE..WAIT_HI)
//   DEF_*         default clock-per-bit, half-bit, FIFO depth and FIFO address width
//   parity_of()   parity of up to 9 data bits, optionally inverted for odd sense
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } rx_state_t;

    localparam int DEF_BAUD_DIV   = 2604;
    localparam int DEF_HALF_BIT   = DEF_BAUD_DIV >> 1;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_FIFO_AW    = $clog2(DEF_FIFO_DEPTH);

    // Callers zero-extend narrower data, so the unused upper bits do not
    // disturb the XOR reduction.
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with occupancy count.
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_data     write port (no overflow protection; caller gates)
//   rd_en              pop head entry (caller must not pop when empty)
//   rd_data            current head entry, valid while count != 0
//   count              entries held, 0..DEPTH
//   full, empty        occupancy flags
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is reset so the show-ahead head reads as zero out of reset.
    // When full, a simultaneous write lands in the slot the read vacates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_rx_fifo_p.sv
// uart_rx_fifo_p: UART receiver (start + data LSB first + [parity] + stop)
// feeding a show-ahead receive FIFO.
//   clk, rst_n   clock, asynchronous active-low reset
//   RX           asynchronous serial input, idle high
//   rd_en        pop FIFO head (ignored when empty)
//   clr_err      clear the sticky error flags
//   rx_data      FIFO head, valid while rdy
//   rdy          FIFO not empty
//   fifo_cnt     entries held
//   frm_err      sticky: stop bit sampled low
//   ovr_err      sticky: frame completed while FIFO full and not being read
//   par_err      sticky: parity mismatch (0 unless UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN to add one parity bit per frame,
// checked against ^data ^ PAR_ODD.
module uart_rx_fifo_p
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEF_BAUD_DIV,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PAR_ODD    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          frm_err,
    output logic                          ovr_err,
    output logic                          par_err
);

    localparam int HALF_BIT = BAUD_DIV >> 1;
    localparam int BW       = $clog2(BAUD_DIV + 1);

    rx_state_t             state;
    logic [1:0]            sync;
    logic                  rxs;
    logic [BW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  push_req;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Two-flop synchroniser, preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RX};
        end
    end

    assign rxs = sync[1];

    // Receiver FSM. baud_cnt counts down to 1, which marks a sample point;
    // the first sample after the start edge lands half a bit in so every
    // later sample sits mid-bit. push_req is a one-cycle pulse the cycle after
    // a good stop sample; shift_reg is stable then because it only moves in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            frm_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            if (clr_err) begin
                frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_err <= 1'b0;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        baud_cnt <= BW'(HALF_BIT);
                    end
                end
                START: begin
                    if (baud_cnt == BW'(1)) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            baud_cnt <= BW'(BAUD_DIV);
                            bit_cnt  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BW'(1)) begin
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        baud_cnt  <= BW'(BAUD_DIV);
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (baud_cnt == BW'(1)) begin
                        state    <= STOP;
                        baud_cnt <= BW'(BAUD_DIV);
                        if (rxs != parity_of(9'(shift_reg), 1'(PAR_ODD))) begin
                            par_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (baud_cnt == BW'(1)) begin
                        if (rxs) begin
                            push_req <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= WAIT_HI;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    // A full FIFO still accepts a byte if the head is popped in the same cycle.
    assign fifo_rd = rd_en && !fifo_empty;
    assign fifo_wr = push_req && (!fifo_full || fifo_rd);

    // Overrun: a completed byte had nowhere to go. Setting wins over clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_err <= 1'b0;
        end else if (push_req && fifo_full && !fifo_rd) begin
            ovr_err <= 1'b1;
        end else if (clr_err) begin
            ovr_err <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (shift_reg),
        .rd_en   (fifo_rd),
        .rd_data (rx_data),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rdy = !fifo_empty;

endmodule
